ssc_dsd_corrector: RTL and testbench

SSC_DSD_CORRECTOR -- requirements
Module: ssc_dsd_corrector

---
 rtl/ssc_dsd_corrector.sv | 173 +++++++++++++++++
 tb/tb_ssc_dsd_corrector.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ssc_dsd_corrector.sv
// Single-symbol-correct / double-symbol-detect corrector over GF(2^8), poly 0x15F.
// Define SSC_DSD_EARLY_TERM_EN to leave SEARCH on the first locator match.
module ssc_dsd_corrector (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         ready_out,
    input  logic [311:0] codeword_in,
    input  logic [7:0]   syndrome0_in,
    input  logic [7:0]   syndrome1_in,
    input  logic [7:0]   syndrome2_in,
    output logic         valid_out,
    input  logic         ready_in,
    output logic [311:0] codeword_out,
    output logic [1:0]   err_type_out,
    output logic [5:0]   err_pos_out
);
    // state  | meaning
    // IDLE   | waiting for a codeword
    // CHECK  | two cycles: seed locators, then classify syndromes
    // SEARCH | one data-symbol candidate k per cycle, k = 0..35
    // DONE   | result presented until downstream accepts
    typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} state_t;

    localparam logic [1:0] ERR_NE  = 2'b00;
    localparam logic [1:0] ERR_CE  = 2'b01;
    localparam logic [1:0] ERR_DUE = 2'b10;
    localparam logic [5:0] K_LAST  = 6'd35;

    state_t         state, state_next;
    logic [311:0]   cw_q;
    logic [7:0]     s0_q, s1_q, s2_q;
    logic [7:0]     t1_q, t2_q;
    logic [5:0]     k_q;
    logic           check_ph;
    logic           found_q;
    logic [5:0]     found_pos_q;

    logic           load_out;
    logic [1:0]     res_type;
    logic [5:0]     res_pos;
    logic           match;
    logic [7:0]     fix_val;
    logic [8:0]     fix_sh;
    logic [311:0]   fix_mask;

    function automatic logic [7:0] mul_alpha(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h5F : 8'h00);
    endfunction

    assign match = (t1_q == s1_q) && (t2_q == s2_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_out   = 1'b0;
        res_type   = ERR_NE;
        res_pos    = 6'd0;
        case (state)
            IDLE: if (valid_in) state_next = CHECK;
            CHECK: if (check_ph) begin
                state_next = DONE;
                load_out   = 1'b1;
                case ({s0_q != 8'h00, s1_q != 8'h00, s2_q != 8'h00})
                    3'b000: res_type = ERR_NE;
                    3'b100: begin res_type = ERR_CE; res_pos = 6'd36; end
                    3'b010: begin res_type = ERR_CE; res_pos = 6'd37; end
                    3'b001: begin res_type = ERR_CE; res_pos = 6'd38; end
                    3'b111: begin state_next = SEARCH; load_out = 1'b0; end
                    default: res_type = ERR_DUE;
                endcase
            end
            SEARCH: begin
`ifdef SSC_DSD_EARLY_TERM_EN
                if (match) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                    res_type   = ERR_CE;
                    res_pos    = k_q;
                end else if (k_q == K_LAST) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                    res_type   = ERR_DUE;
                end
`else
                if (k_q == K_LAST) begin
                    state_next = DONE;
                    load_out   = 1'b1;
                    if (found_q) begin
                        res_type = ERR_CE;
                        res_pos  = found_pos_q;
                    end else if (match) begin
                        res_type = ERR_CE;
                        res_pos  = k_q;
                    end else begin
                        res_type = ERR_DUE;
                    end
                end
`endif
            end
            DONE: if (ready_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state == IDLE) && !rst;
        valid_out = (state == DONE);
    end

    // Symbol p sits at [311-8p -: 8] for data and parity alike, so one shift covers all.
    always_comb begin
        fix_val  = (res_pos == 6'd37) ? s1_q : (res_pos == 6'd38) ? s2_q : s0_q;
        fix_sh   = 9'(6'd38 - res_pos) << 3;
        fix_mask = '0;
        if (res_type == ERR_CE) fix_mask = 312'(fix_val) << fix_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_q         <= '0;
            s0_q         <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            t1_q         <= '0;
            t2_q         <= '0;
            k_q          <= '0;
            check_ph     <= 1'b0;
            found_q      <= 1'b0;
            found_pos_q  <= '0;
            codeword_out <= '0;
            err_type_out <= ERR_NE;
            err_pos_out  <= '0;
        end else begin
            case (state)
                IDLE: if (valid_in) begin
                    cw_q     <= codeword_in;
                    s0_q     <= syndrome0_in;
                    s1_q     <= syndrome1_in;
                    s2_q     <= syndrome2_in;
                    check_ph <= 1'b0;
                    found_q  <= 1'b0;
                    k_q      <= '0;
                end
                CHECK: begin
                    check_ph <= 1'b1;
                    t1_q     <= s0_q;
                    t2_q     <= s0_q;
                    k_q      <= '0;
                end
                SEARCH: begin
                    t1_q <= mul_alpha(t1_q);
                    t2_q <= mul_alpha(mul_alpha(t2_q));
                    k_q  <= k_q + 6'd1;
                    if (match && !found_q) begin
                        found_q     <= 1'b1;
                        found_pos_q <= k_q;
                    end
                end
                default: ;
            endcase
            if (load_out) begin
                codeword_out <= cw_q ^ fix_mask;
                err_type_out <= res_type;
                err_pos_out  <= res_pos;
            end
        end
    end
endmodule

// File: tb/tb_ssc_dsd_corrector.sv
// Directed bench for ssc_dsd_corrector: classification, correction, latency,
// backpressure and mid-search reset.
module tb_ssc_dsd_corrector;
`ifdef SSC_DSD_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         valid_in = 1'b0;
    logic         ready_out;
    logic [311:0] codeword_in = '0;
    logic [7:0]   syndrome0_in = '0, syndrome1_in = '0, syndrome2_in = '0;
    logic         valid_out;
    logic         ready_in = 1'b0;
    logic [311:0] codeword_out;
    logic [1:0]   err_type_out;
    logic [5:0]   err_pos_out;

    int errs = 0;
    int checks = 0;

    ssc_dsd_corrector dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .codeword_in(codeword_in), .syndrome0_in(syndrome0_in),
        .syndrome1_in(syndrome1_in), .syndrome2_in(syndrome2_in),
        .valid_out(valid_out), .ready_in(ready_in), .codeword_out(codeword_out),
        .err_type_out(err_type_out), .err_pos_out(err_pos_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [311:0] got, input logic [311:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_x2(input logic [7:0] x);
        logic [8:0] y;
        y = {x, 1'b0};
        if (y[8]) y = y ^ 9'h15F;
        return y[7:0];
    endfunction

    function automatic int search_lat(input int k);
        return EARLY ? 3 + k : 38;
    endfunction

    function automatic logic [311:0] flip(input logic [311:0] cw, input int p, input logic [7:0] v);
        logic [311:0] r;
        r = cw;
        r[311-8*p -: 8] = r[311-8*p -: 8] ^ v;
        return r;
    endfunction

    task automatic start(input logic [311:0] cw, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input string tag);
        int n;
        n = 0;
        while (!ready_out && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rdy"}, 312'(ready_out), 312'(1));
        codeword_in  = cw;
        syndrome0_in = a;
        syndrome1_in = b;
        syndrome2_in = c;
        valid_in     = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic run(input string tag, input logic [311:0] cw, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input int lat_exp,
                       input logic [1:0] ty, input logic [5:0] pos,
                       input logic [311:0] cw_exp, input int hold);
        int lat;
        logic [311:0] cw_seen;
        start(cw, a, b, c, tag);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (valid_out) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, 312'(lat), 312'(lat_exp));
        chk({tag, "_type"}, 312'(err_type_out), 312'(ty));
        chk({tag, "_pos"}, 312'(err_pos_out), 312'(pos));
        chk({tag, "_cw"}, codeword_out, cw_exp);
        cw_seen = codeword_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) begin
            chk({tag, "_hold_valid"}, 312'(valid_out), 312'(1));
            chk({tag, "_hold_cw"}, codeword_out, cw_exp);
            chk({tag, "_hold_rdy"}, 312'(ready_out), 312'(0));
            chk({tag, "_hold_pos"}, 312'(err_pos_out), 312'(pos));
        end
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        chk({tag, "_idle_rdy"}, 312'(ready_out), 312'(1));
        chk({tag, "_idle_valid"}, 312'(valid_out), 312'(0));
    endtask

    logic [311:0] base;
    logic [7:0]   s1_35, s2_35, t;

    initial begin
        for (int k = 0; k < 39; k++) base[311-8*k -: 8] = 8'(k * 7 + 3);

        s1_35 = 8'h80;
        for (int i = 0; i < 35; i++) s1_35 = gf_x2(s1_35);
        s2_35 = 8'h80;
        for (int i = 0; i < 70; i++) s2_35 = gf_x2(s2_35);

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 312'(valid_out), 312'(0));
        chk("rst_ready", 312'(ready_out), 312'(0));
        chk("rst_cw", codeword_out, '0);
        chk("rst_type", 312'(err_type_out), 312'(0));
        chk("rst_pos", 312'(err_pos_out), 312'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_ready", 312'(ready_out), 312'(1));

        run("ne_zero", '0, 8'h00, 8'h00, 8'h00, 2, 2'b00, 6'd0, '0, 0);
        run("sym1", base, 8'h05, 8'h0A, 8'h14, search_lat(1), 2'b01, 6'd1,
            base ^ {8'h00, 8'h05, 296'h0}, 0);
        run("p1", base, 8'h00, 8'h3C, 8'h00, 2, 2'b01, 6'd37, flip(base, 37, 8'h3C), 0);
        run("p0", base, 8'hA7, 8'h00, 8'h00, 2, 2'b01, 6'd36, flip(base, 36, 8'hA7), 0);
        run("p2", base, 8'h00, 8'h00, 8'h7E, 2, 2'b01, 6'd38, flip(base, 38, 8'h7E), 0);
        run("due2", base, 8'h11, 8'h22, 8'h00, 2, 2'b10, 6'd0, base, 0);
        run("due_srch", base, 8'h01, 8'h01, 8'h02, 38, 2'b10, 6'd0, base, 0);
        run("sym0", base, 8'h33, 8'h33, 8'h33, search_lat(0), 2'b01, 6'd0,
            flip(base, 0, 8'h33), 0);
        run("sym35", base, 8'h80, s1_35, s2_35, search_lat(35), 2'b01, 6'd35,
            flip(base, 35, 8'h80), 0);
        run("bp", base, 8'h00, 8'h00, 8'h00, 2, 2'b00, 6'd0, base, 5);

        // Abort a search at k=10, then confirm the block recovers cleanly.
        t = 8'h05;
        start(base, t, 8'h0A, 8'h14, "rst_mid");
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_valid", 312'(valid_out), 312'(0));
        chk("mid_cw", codeword_out, '0);
        chk("mid_type", 312'(err_type_out), 312'(0));
        chk("mid_pos", 312'(err_pos_out), 312'(0));
        chk("mid_ready", 312'(ready_out), 312'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", 312'(ready_out), 312'(1));
        run("post_rst_ne", base, 8'h00, 8'h00, 8'h00, 2, 2'b00, 6'd0, base, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
